// File: rtl/dcache_pkg.sv
// Shared types and address-field helpers for the direct-mapped write-through data cache.
package dcache_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      FILL = 1'b1
   } state_t;

   localparam int TAG_BITS   = 9;
   localparam int INDEX_BITS = 4;
   localparam int WORD_BITS  = 2;
   localparam int DATA_BITS  = 16;

   function automatic logic [TAG_BITS-1:0] addr_tag(input logic [15:0] a);
      return a[15:7];
   endfunction

   function automatic logic [INDEX_BITS-1:0] addr_index(input logic [15:0] a);
      return a[6:3];
   endfunction

   function automatic logic [WORD_BITS-1:0] addr_word(input logic [15:0] a);
      return a[2:1];
   endfunction

endpackage

// File: rtl/dcache_array.sv
// Valid/tag/data storage: combinational lookup, one word-write port, one tag/valid write port.
module dcache_array
   import dcache_pkg::*;
#(
   parameter int IDX_W = INDEX_BITS,
   parameter int TAG_W = TAG_BITS
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic [IDX_W-1:0]      rd_index,
   input  logic [TAG_W-1:0]      rd_tag,
   input  logic [WORD_BITS-1:0]  rd_word,
   output logic                  hit,
   output logic [DATA_BITS-1:0]  rd_data,
   input  logic                  word_we,
   input  logic [IDX_W-1:0]      word_index,
   input  logic [WORD_BITS-1:0]  word_sel,
   input  logic [DATA_BITS-1:0]  word_data,
   input  logic                  tag_we,
   input  logic [IDX_W-1:0]      tag_index,
   input  logic [TAG_W-1:0]      tag_data
);

   localparam int LINES = 1 << IDX_W;
   localparam int WORDS = 1 << WORD_BITS;

   logic [LINES-1:0]     valid_reg;
   logic [TAG_W-1:0]     tag_mem  [LINES];
   logic [DATA_BITS-1:0] data_mem [LINES][WORDS];

   // Valid bits are the only state that must clear on reset; tags and data stay as-is.
   for (genvar gi = 0; gi < LINES; gi++) begin : g_valid
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            valid_reg[gi] <= 1'b0;
         end else if (tag_we && (tag_index == IDX_W'(gi))) begin
            valid_reg[gi] <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (tag_we) begin
         tag_mem[tag_index] <= tag_data;
      end
      if (word_we) begin
         data_mem[word_index][word_sel] <= word_data;
      end
   end

   assign hit     = valid_reg[rd_index] && (tag_mem[rd_index] == rd_tag);
   assign rd_data = data_mem[rd_index][rd_word];

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-through, no-write-allocate cache controller; read misses stall for a 4-word fill.
module dcache_ctrl
   import dcache_pkg::*;
#(
   parameter int ADDR_WIDTH = 16,
   parameter int INDEX_BITS = 4
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [15:0]           data_in,
   input  logic                  rd,
   input  logic                  wr,
   output logic [15:0]           data_out,
   output logic                  done,
   output logic                  stall,
   output logic                  cache_hit,
   output logic                  err,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [15:0]           mem_data_in,
   output logic                  mem_enable,
   output logic                  mem_wr,
   input  logic [15:0]           mem_data_out
);

   localparam int TAG_W = ADDR_WIDTH - INDEX_BITS - WORD_BITS - 1;

   state_t                 state_reg, state_next;
   logic [WORD_BITS-1:0]   cnt_reg, cnt_next;
   logic                   miss_seen_reg, miss_seen_next;

   logic [TAG_W-1:0]       req_tag;
   logic [INDEX_BITS-1:0]  req_index;
   logic [WORD_BITS-1:0]   req_word;
   logic                   req_any;
   logic                   req_bad;

   logic                   arr_hit;
   logic [15:0]            arr_data;
   logic                   word_we;
   logic [WORD_BITS-1:0]   word_sel;
   logic [15:0]            word_data;
   logic                   tag_we;

   assign req_tag   = addr_tag(addr);
   assign req_index = addr_index(addr);
   assign req_word  = addr_word(addr);
   assign req_any   = rd | wr;
   assign req_bad   = (rd & wr) | (req_any & addr[0]);

   dcache_array #(
      .IDX_W (INDEX_BITS),
      .TAG_W (TAG_W)
   ) u_array (
      .clk        (clk),
      .rst        (rst),
      .rd_index   (req_index),
      .rd_tag     (req_tag),
      .rd_word    (req_word),
      .hit        (arr_hit),
      .rd_data    (arr_data),
      .word_we    (word_we),
      .word_index (req_index),
      .word_sel   (word_sel),
      .word_data  (word_data),
      .tag_we     (tag_we),
      .tag_index  (req_index),
      .tag_data   (req_tag)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg     <= IDLE;
         cnt_reg       <= '0;
         miss_seen_reg <= 1'b0;
      end else begin
         state_reg     <= state_next;
         cnt_reg       <= cnt_next;
         miss_seen_reg <= miss_seen_next;
      end
   end

   always_comb begin
      state_next     = state_reg;
      cnt_next       = cnt_reg;
      miss_seen_next = miss_seen_reg;
      data_out       = '0;
      done           = 1'b0;
      cache_hit      = 1'b0;
      err            = 1'b0;
      mem_addr       = '0;
      mem_data_in    = '0;
      mem_enable     = 1'b0;
      mem_wr         = 1'b0;
      word_we        = 1'b0;
      word_sel       = req_word;
      word_data      = data_in;
      tag_we         = 1'b0;
      // Outputs are gated by rst so nothing completes or touches memory while reset is held.
      if (!rst) begin
         case (state_reg)
            IDLE: begin
               if (req_bad) begin
                  done = 1'b1;
                  err  = 1'b1;
               end else if (rd) begin
                  if (arr_hit) begin
                     done           = 1'b1;
                     data_out       = arr_data;
                     cache_hit      = ~miss_seen_reg;
                     miss_seen_next = 1'b0;
                  end else begin
                     state_next     = FILL;
                     cnt_next       = '0;
                     miss_seen_next = 1'b1;
                  end
               end else if (wr) begin
                  mem_enable  = 1'b1;
                  mem_wr      = 1'b1;
                  mem_addr    = addr;
                  mem_data_in = data_in;
                  done        = 1'b1;
                  cache_hit   = arr_hit;
                  word_we     = arr_hit;
               end
            end
            FILL: begin
               mem_enable = 1'b1;
               mem_addr   = {req_tag, req_index, cnt_reg, 1'b0};
               word_we    = 1'b1;
               word_sel   = cnt_reg;
               word_data  = mem_data_out;
               cnt_next   = cnt_reg + 1'b1;
               if (cnt_reg == '1) begin
                  tag_we     = 1'b1;
                  state_next = IDLE;
               end
            end
            default: state_next = IDLE;
         endcase
      end
   end

   assign stall = req_any & ~done;

endmodule
